// File: rtl/fsm_q3_state_tracker_if.sv
// q3 state tracker bundle: serial input, debug load port and registered status.
// Master drives stimulus and load; slave (the tracker) returns y/z/z_count/err.
// Pure signal grouping, no storage and no added latency.
interface fsm_q3_state_tracker_if #(
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             state_load;
    logic [2:0]       state_in;
    logic [2:0]       y;
    logic             z;
    logic [CNT_W-1:0] z_count;
    logic             err;

    modport master (
        output x, x_valid, state_load, state_in,
        input  y, z, z_count, err
    );

    modport slave (
        input  x, x_valid, state_load, state_in,
        output y, z, z_count, err
    );
endinterface

// File: rtl/fsm_q3_state_tracker.sv
// Registered q3 five-state tracker with Moore z, saturating z-cycle count and sticky err.
// Latency: y/z_count/err update on the edge after an accepted input; z decodes registered y.
// Backpressure: none; x is consumed only when x_valid=1, otherwise all state holds.
module fsm_q3_state_tracker #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_q3_state_tracker_if.slave bus
);
    typedef enum logic [2:0] {
        S_000 = 3'd0,
        S_001 = 3'd1,
        S_010 = 3'd2,
        S_011 = 3'd3,
        S_100 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_cur;
    logic             state_bad;

    assign z_cur     = (state_q == S_011) || (state_q == S_100);
    assign state_bad = (3'(state_q) > 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (bus.state_load) begin
            if (bus.state_in > 3'd4) begin
                state_d = S_000;
                err_d   = 1'b1;
            end else begin
                state_d = state_t'(bus.state_in);
            end
        end else if (state_bad) begin
            // Upset/forced illegal code: recover to 000 without waiting for x_valid.
            state_d = S_000;
            err_d   = 1'b1;
        end else if (bus.x_valid) begin
            if (z_cur && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_000:   state_d = bus.x ? S_001 : S_000;
                S_001:   state_d = bus.x ? S_100 : S_001;
                S_010:   state_d = bus.x ? S_001 : S_010;
                S_011:   state_d = bus.x ? S_010 : S_001;
                S_100:   state_d = bus.x ? S_100 : S_011;
                default: state_d = S_000;
            endcase
        end
    end

    assign bus.y       = 3'(state_q);
    assign bus.z       = z_cur;
    assign bus.z_count = cnt_q;
    assign bus.err     = err_q;
endmodule
